mosfet_search: RTL

MOSFET_SEARCH -- requirements
Module: mosfet_search

---
 rtl/mosfet_search_if.sv | 23 ++
 rtl/mosfet_search.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mosfet_search_if.sv
// Start/result bus of the MOSFET operating-point search engine.
interface mosfet_search_if;
    logic       in_valid;
    logic       mode;
    logic [6:0] target;
    logic       busy;
    logic       out_valid;
    logic [2:0] out_w;
    logic [2:0] out_vgs;
    logic [2:0] out_vds;
    logic [6:0] out_value;
    logic       out_exact;

    modport master (
        output in_valid, mode, target,
        input  busy, out_valid, out_w, out_vgs, out_vds, out_value, out_exact
    );

    modport slave (
        input  in_valid, mode, target,
        output busy, out_valid, out_w, out_vgs, out_vds, out_value, out_exact
    );
endinterface

// File: rtl/mosfet_search.sv
// Exhaustive search over {W,VGS,VDS} for the device value closest to a target.
// Optional macro SMC_SEARCH_EXACT_STOP_EN ends the scan at the first exact match.
module mosfet_search (
    input logic            clk,
    input logic            rst,
    mosfet_search_if.slave bus
);
`ifdef SMC_SEARCH_EXACT_STOP_EN
    localparam bit EXACT_STOP = 1'b1;
`else
    localparam bit EXACT_STOP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, next_state;
    logic              mode_q;
    logic        [6:0] target_q;
    logic        [8:0] idx;
    logic        [7:0] best_err;
    logic        [8:0] best_idx;
    logic        [6:0] best_value;
    logic        [6:0] value_p0;
    logic              vld_p1;
    logic        [8:0] idx_p1;
    logic        [6:0] value_p1;
    logic        [7:0] err_p1;
    logic              take_p1;
    logic              last_p1;
    logic        [8:0] cand_idx;
    logic        [6:0] cand_value;
    logic        [2:0] res_w, res_vgs, res_vds;
    logic        [6:0] res_value;
    logic              res_exact;
    logic              busy, out_valid;

    // Products are formed at 12 bits so nothing is lost before the divide by 3.
    function automatic logic [6:0] dev_value(input logic m, input logic [2:0] w,
                                             input logic [2:0] vgs, input logic [2:0] vds);
        logic [11:0] ww, ds, gs1, prod;
        ww  = {9'd0, w};
        ds  = {9'd0, vds};
        gs1 = {9'd0, vgs} - 12'd1;
        if (vgs <= 3'd1)
            prod = 12'd0;
        else if ({1'b0, vgs} > {1'b0, vds} + 4'd1)
            prod = m ? ds * ww * ((gs1 << 1) - ds) : (ww * ds) << 1;
        else
            prod = m ? ww * gs1 * gs1 : (ww * gs1) << 1;
        return 7'(prod / 12'd3);
    endfunction

    function automatic logic [7:0] abs_err(input logic [6:0] v, input logic [6:0] t);
        logic signed [8:0] d;
        d = $signed({2'b00, v}) - $signed({2'b00, t});
        return (d < 0) ? 8'(-d) : 8'(d);
    endfunction

    // p0: evaluate the combination addressed by idx
    assign value_p0 = dev_value(mode_q, idx[8:6], idx[5:3], idx[2:0]);

    // p1: compare the registered evaluation against the running best
    assign err_p1     = abs_err(value_p1, target_q);
    assign take_p1    = err_p1 < best_err;
    assign cand_idx   = take_p1 ? idx_p1 : best_idx;
    assign cand_value = take_p1 ? value_p1 : best_value;
    assign last_p1    = vld_p1 && ((idx_p1 == 9'd511) || (EXACT_STOP && err_p1 == 8'd0));

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) next_state = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (last_p1) next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vld_p1    <= 1'b0;
            idx       <= 9'd0;
            best_err  <= 8'd255;
            res_w     <= 3'd0;
            res_vgs   <= 3'd0;
            res_vds   <= 3'd0;
            res_value <= 7'd0;
            res_exact <= 1'b0;
        end else begin
            state  <= next_state;
            vld_p1 <= (state == SCAN);
            if (state == IDLE && bus.in_valid) begin
                idx      <= 9'd0;
                best_err <= 8'd255;
            end else if (state == SCAN) begin
                idx <= idx + 9'd1;
                if (vld_p1 && take_p1) best_err <= err_p1;
                if (last_p1) begin
                    res_w     <= cand_idx[8:6];
                    res_vgs   <= cand_idx[5:3];
                    res_vds   <= cand_idx[2:0];
                    res_value <= cand_value;
                    res_exact <= (cand_value == target_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        value_p1 <= value_p0;
        idx_p1   <= idx;
        if (state == IDLE && bus.in_valid) begin
            mode_q   <= bus.mode;
            target_q <= bus.target;
        end
        if (state == SCAN && vld_p1 && take_p1) begin
            best_idx   <= idx_p1;
            best_value <= value_p1;
        end
    end

    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.out_w     = res_w;
    assign bus.out_vgs   = res_vgs;
    assign bus.out_vds   = res_vds;
    assign bus.out_value = res_value;
    assign bus.out_exact = res_exact;
endmodule
